// File: rtl/sseg_brightness_ctrl.sv
// Push-button brightness controller for the seven-segment PWM path.
// Ports: clk, reset (async, active high), btn_up/btn_down/btn_blank (raw),
//        pwm_control (duty 0..2^PWM_RESOLUTION), at_max, at_min (registered).
module sseg_brightness_ctrl #(
    parameter int PWM_RESOLUTION = 4,
    parameter int DB_COUNT_WIDTH = 20,
    parameter int RESET_LEVEL    = 2 ** PWM_RESOLUTION
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_blank,
    output logic [PWM_RESOLUTION:0]   pwm_control,
    output logic                      at_max,
    output logic                      at_min
);

    localparam int NB = 3;
    localparam int LW = PWM_RESOLUTION + 1;
    localparam logic [LW-1:0] LVL_MAX = {1'b1, {PWM_RESOLUTION{1'b0}}};
    localparam logic [LW-1:0] LVL_ONE = {{PWM_RESOLUTION{1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_RST = LW'(RESET_LEVEL);
    localparam logic [DB_COUNT_WIDTH-1:0] CNT_ONE =
        {{(DB_COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_e;

    logic [NB-1:0] raw, sync1, sync2, tick;

    // bit 0 = up, bit 1 = down, bit 2 = blank
    assign raw = {btn_blank, btn_down, btn_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_db
        db_state_e                 st_q, st_d;
        logic [DB_COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                      tk;
        logic                      in;

        assign in      = sync2[i];
        assign tick[i] = tk;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q  <= ZERO;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        // Only the confirmed press (WAIT1 -> ONE) produces a tick.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            tk    = 1'b0;
            unique case (st_q)
                ZERO: begin
                    if (in) begin
                        cnt_d = '1;
                        st_d  = WAIT1;
                    end
                end
                WAIT1: begin
                    if (!in) begin
                        st_d = ZERO;
                    end else if (cnt_q == '0) begin
                        st_d = ONE;
                        tk   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ONE: begin
                    if (!in) begin
                        cnt_d = '1;
                        st_d  = WAIT0;
                    end
                end
                WAIT0: begin
                    if (in) begin
                        st_d = ONE;
                    end else if (cnt_q == '0) begin
                        st_d = ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            endcase
        end
    end

    logic [LW-1:0] level_q, level_d;
    logic          blank_q, blank_d;

    // Simultaneous up and down ticks cancel; blank applies independently.
    always_comb begin
        level_d = level_q;
        blank_d = blank_q ^ tick[2];
        if (tick[0] && !tick[1] && level_q != LVL_MAX) begin
            level_d = level_q + LVL_ONE;
        end else if (tick[1] && !tick[0] && level_q != '0) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // Outputs are registered from the next-state values so they move on
    // the same edge as the level itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q     <= LVL_RST;
            blank_q     <= 1'b0;
            pwm_control <= LVL_RST;
            at_max      <= (LVL_RST == LVL_MAX);
            at_min      <= (LVL_RST == '0);
        end else begin
            level_q     <= level_d;
            blank_q     <= blank_d;
            pwm_control <= blank_d ? '0 : level_d;
            at_max      <= (level_d == LVL_MAX);
            at_min      <= (level_d == '0);
        end
    end

endmodule
